util_iic_sel_ctrl: RTL
======================

Name: util_iic_sel_ctrl

Overview:
- Bus-aware controller for the per-slave chip-select lines (cs_n) of the IIC fan-out buffer.
- Watches the shared SCL/SDA lines seen by the IIC master and detects START and STOP conditions.
- Accepts slave-select requests over a valid/ready handshake, but changes cs_n only when the bus is idle. Switching is break-before-make.
- A stuck-SCL watchdog force-deselects all slaves and reports an error.

Parameters:
- SLAVE_NUM, 4, number of slave channels; width of cs_n and sel_mask.
- IDLE_CYCLES, 16, minimum bus-free clk cycles after a STOP before sel_ready may assert (≥1).
- GAP_CYCLES, 4, cycles with all cs_n high between old and new selection (≥1).
- TIMEOUT_CYCLES, 65535, cycles of SCL held low while busy before the watchdog fires. 0 disables the watchdog.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst  in  1  synchronous reset, active-high.
- scl_in  in  1  observed bus SCL (wired-AND value returned to the master). Treated as asynchronous.
- sda_in  in  1  observed bus SDA. Treated as asynchronous.
- sel_valid  in  1  select request valid.
- sel_ready  out  1  controller can accept a select request.
- sel_mask  in  SLAVE_NUM  one-hot or multi-hot target set; bit=1 selects that slave.
- cs_n  out  SLAVE_NUM  active-low slave selects to the fan-out block.
- cur_mask  out  SLAVE_NUM  currently applied selection; equals ~cs_n outside SWITCH.
- bus_busy  out  1  high between a detected START and the matching STOP.
- start_err  out  1  one-cycle pulse: START detected during SWITCH.
- timeout_err  out  1  one-cycle pulse: watchdog fired.

Behaviour:
- Reset values: cs_n all 1, cur_mask 0, sel_ready 0, bus_busy 0, start_err 0, timeout_err 0. Synchronizer flops reset to 1. State is FREE_WAIT with the counter cleared.
- Input sync: scl_in/sda_in each pass through 2 flops, then one history flop.
- START detect: prev_sda=1, sda=0, scl=1 (synced values). STOP detect: prev_sda=0, sda=1, scl=1.
- Detection latency is 3 clk from a pin edge. At most one of start_det/stop_det is asserted per cycle.
- States: IDLE, BUSY, FREE_WAIT, SWITCH.
- IDLE:
  - sel_ready=1.
  - sel_valid & sel_ready with sel_mask==cur_mask: accepted, no cs_n change, stay IDLE.
  - Accepted with a different mask: next cycle cs_n = all 1, sel_ready=0, enter SWITCH with the gap counter cleared.
  - start_det: enter BUSY and set bus_busy. If start_det and a handshake occur in the same cycle, the request is still accepted. The master must not start while a switch is pending, so a START arriving in the following SWITCH flags start_err.
- SWITCH:
  - cs_n is held all 1 for exactly GAP_CYCLES cycles.
  - Then cs_n = ~sel_mask_latched and cur_mask = sel_mask_latched, both registered, and the state returns to IDLE (sel_ready=1 on that same cycle).
  - sel_mask = 0 is legal and leaves all slaves deselected.
  - start_det in SWITCH: one-cycle start_err pulse and bus_busy=1. The switch still completes, then the state goes to BUSY instead of IDLE.
- BUSY:
  - sel_ready=0, bus_busy=1.
  - A repeated START keeps the state in BUSY.
  - stop_det: enter FREE_WAIT, clear bus_busy, and load the idle counter.
  - Watchdog: counts consecutive cycles with synced scl=0 and clears whenever scl=1. On reaching TIMEOUT_CYCLES (nonzero): one-cycle timeout_err pulse, cs_n all 1, cur_mask 0, bus_busy 0, enter FREE_WAIT.
- FREE_WAIT:
  - sel_ready=0.
  - The idle counter increments each cycle. When it reaches IDLE_CYCLES the state goes to IDLE. sel_ready therefore first asserts exactly IDLE_CYCLES+1 cycles after the stop_det cycle.
  - start_det in FREE_WAIT: return to BUSY and clear the counter.
- sel_mask is latched only on a handshake. Changes to sel_mask while sel_valid is low, or while ready is low, have no effect.
- Counter widths are sized by $clog2 of the larger of each parameter+1. No wrap-around is allowed; counters saturate at their terminal value.
- rst asserted in any state: the next cycle is reset values. Pending selections are discarded.

Test Plan:
- Reset, lines idle high:
  - cs_n=4'b1111 and sel_ready=0 for 17 cycles, then sel_ready=1.
  - sel_mask=4'b0100 handshake → cs_n=1111 for 4 cycles, then 4'b1011, cur_mask=0100.
- Same-mask request:
  - With cur_mask=0100, request 0100 → accepted in 1 cycle, cs_n stays 1011 with no all-ones gap.
- Full transaction:
  - START (SDA fall, SCL high) → bus_busy=1 three cycles later, sel_ready=0.
  - STOP → bus_busy=0.
  - sel_ready returns exactly 17 cycles after stop_det; a request held valid during BUSY is accepted only then.
- START during FREE_WAIT at counter=8:
  - Back to BUSY, sel_ready stays 0.
  - After the next STOP, a full 17-cycle wait is required.
- Watchdog:
  - TIMEOUT_CYCLES=100, SCL held low after START → timeout_err pulses once at cycle 100 of low SCL, cs_n=1111, cur_mask=0, bus_busy=0.
  - With TIMEOUT_CYCLES=0, no pulse ever.
- START injected during SWITCH:
  - start_err pulses once, new cs_n is still applied after the gap, state goes to BUSY with sel_ready=0.
- rst mid-SWITCH: cs_n=1111, sel_ready=0 next cycle.

Source files
------------

// File: rtl/util_iic_sel_ctrl.sv
// util_iic_sel_ctrl: bus-aware chip-select controller for an IIC fan-out buffer.
// Switches selects only while the bus is idle, break-before-make, with an SCL-stuck watchdog.
module util_iic_sel_ctrl #(
  parameter int SLAVE_NUM      = 4,
  parameter int IDLE_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scl_in,
  input  logic                 sda_in,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  input  logic [SLAVE_NUM-1:0] sel_mask,
  output logic [SLAVE_NUM-1:0] cs_n,
  output logic [SLAVE_NUM-1:0] cur_mask,
  output logic                 bus_busy,
  output logic                 start_err,
  output logic                 timeout_err
);
  localparam int CMAX = (IDLE_CYCLES > GAP_CYCLES) ? IDLE_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam int WW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CMAX_L = CW'(CMAX);
  localparam logic [CW-1:0] IDLE_L = CW'(IDLE_CYCLES);
  localparam logic [CW-1:0] GAP_L = CW'(GAP_CYCLES);
  localparam logic [WW-1:0] TO_L = WW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = TIMEOUT_CYCLES != 0;

  typedef enum logic [1:0] {IDLE, BUSY, FREE_WAIT, SWITCH} state_t;

  state_t r_state, w_state, r_ret, w_ret;
  logic r_scl_m, r_scl, r_sda_m, r_sda, r_sda_prev;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [WW-1:0] r_wd, w_wd, w_wd_inc;
  logic [SLAVE_NUM-1:0] r_mask, w_mask, r_cs_n, w_cs_n, r_cur, w_cur;
  logic r_busy, w_busy, r_start_err, w_start_err, r_timeout_err, w_timeout_err;
  logic w_start, w_stop, w_fire;

  assign w_start = r_scl & r_sda_prev & ~r_sda;
  assign w_stop = r_scl & ~r_sda_prev & r_sda;
  assign w_cnt_inc = (r_cnt == CMAX_L) ? r_cnt : r_cnt + CW'(1);
  assign w_wd_inc = (r_wd == TO_L) ? r_wd : r_wd + WW'(1);
  assign w_fire = WD_EN && (r_state == BUSY) && !r_scl && (w_wd_inc == TO_L);

  // r_ret remembers where a running switch lands once the gap has elapsed
  always_comb begin
    w_state = r_state;
    w_ret = r_ret;
    w_cnt = w_cnt_inc;
    w_wd = '0;
    w_mask = r_mask;
    w_cs_n = r_cs_n;
    w_cur = r_cur;
    w_busy = r_busy;
    w_start_err = 1'b0;
    w_timeout_err = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt = '0;
        if (sel_valid && sel_mask != r_cur) begin
          w_state = SWITCH;
          w_mask = sel_mask;
          w_cs_n = '1;
          w_ret = w_start ? BUSY : IDLE;
          w_busy = w_start;
        end else if (w_start) begin
          w_state = BUSY;
          w_busy = 1'b1;
        end
      end
      SWITCH: begin
        if (w_start) begin
          w_start_err = 1'b1;
          w_busy = 1'b1;
          w_ret = BUSY;
        end else if (w_stop && r_busy) begin
          w_busy = 1'b0;
          w_ret = FREE_WAIT;
        end
        if (w_cnt_inc >= GAP_L) begin
          w_state = w_ret;
          w_cs_n = ~r_mask;
          w_cur = r_mask;
          w_cnt = '0;
        end
      end
      BUSY: begin
        w_cnt = '0;
        w_wd = r_scl ? '0 : w_wd_inc;
        if (w_fire) begin
          w_timeout_err = 1'b1;
          w_cs_n = '1;
          w_cur = '0;
          w_busy = 1'b0;
          w_wd = '0;
          w_state = FREE_WAIT;
        end else if (w_stop) begin
          w_busy = 1'b0;
          w_state = FREE_WAIT;
        end
      end
      default: begin
        if (w_start) begin
          w_state = BUSY;
          w_busy = 1'b1;
          w_cnt = '0;
        end else if (w_cnt_inc >= IDLE_L) begin
          w_state = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_m <= 1'b1;
      r_scl <= 1'b1;
      r_sda_m <= 1'b1;
      r_sda <= 1'b1;
      r_sda_prev <= 1'b1;
      r_state <= FREE_WAIT;
      r_ret <= IDLE;
      r_cnt <= '0;
      r_wd <= '0;
      r_mask <= '0;
      r_cs_n <= '1;
      r_cur <= '0;
      r_busy <= 1'b0;
      r_start_err <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_scl_m <= scl_in;
      r_scl <= r_scl_m;
      r_sda_m <= sda_in;
      r_sda <= r_sda_m;
      r_sda_prev <= r_sda;
      r_state <= w_state;
      r_ret <= w_ret;
      r_cnt <= w_cnt;
      r_wd <= w_wd;
      r_mask <= w_mask;
      r_cs_n <= w_cs_n;
      r_cur <= w_cur;
      r_busy <= w_busy;
      r_start_err <= w_start_err;
      r_timeout_err <= w_timeout_err;
    end
  end

  assign sel_ready = r_state == IDLE;
  assign cs_n = r_cs_n;
  assign cur_mask = r_cur;
  assign bus_busy = r_busy;
  assign start_err = r_start_err;
  assign timeout_err = r_timeout_err;
endmodule
